// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch: multicycle MIPS fetch stage (PC, IR, req/ack imem handshake).
// Optional: FETCH_TIMEOUT_EN adds a 16-cycle fetch timeout and fetch_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic [31:0] pc,
`ifdef FETCH_TIMEOUT_EN
   output logic        fetch_err,
`endif
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        r_valid;
   logic        r_pend;
   logic [31:0] r_pend_tgt;
   logic        r_defer;
   logic [31:0] w_target;
   logic        w_start;
`ifdef FETCH_TIMEOUT_EN
   logic [3:0]  r_tmo;
   logic        r_err;
`endif

   assign w_target = branch_target & c_WORD_MASK;
   // A fetch that lost to a same-cycle branch is replayed from the target.
   assign w_start  = fetch_en | r_defer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC & c_WORD_MASK;
         r_instr    <= 32'd0;
         r_instr_pc <= 32'd0;
         r_valid    <= 1'b0;
         r_pend     <= 1'b0;
         r_pend_tgt <= 32'd0;
         r_defer    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         r_tmo      <= 4'd0;
         r_err      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_HOLD: begin
               if (branch_taken) begin
                  r_pc    <= w_target;
                  r_pend  <= 1'b0;
                  r_defer <= w_start;
               end else if (w_start) begin
                  r_state <= S_REQ;
                  r_valid <= 1'b0;
                  r_defer <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                  r_tmo   <= 4'd0;
                  r_err   <= 1'b0;
`endif
               end
            end
            S_REQ: begin
               if (branch_taken) begin
                  r_pend     <= 1'b1;
                  r_pend_tgt <= w_target;
               end
               if (imem_ack) begin
                  r_instr    <= imem_rdata;
                  r_instr_pc <= r_pc;
                  r_valid    <= 1'b1;
                  r_pend     <= 1'b0;
                  r_state    <= S_HOLD;
                  if (branch_taken)
                     r_pc <= w_target;
                  else if (r_pend)
                     r_pc <= r_pend_tgt;
                  else
                     r_pc <= r_pc + 32'd4;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (r_tmo == 4'hF) begin
                  r_instr <= 32'd0;
                  r_valid <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= S_HOLD;
               end else begin
                  r_tmo <= r_tmo + 4'd1;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_req    = (r_state == S_REQ);
   assign busy        = (r_state == S_REQ);
   assign imem_addr   = imem_req ? r_pc : 32'd0;
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign instr_pc    = r_instr_pc;
   assign pc          = r_pc;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch: directed self-checking bench for instr_fetch (RESET_PC=0x100).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [31:0] pc;
   logic        busy;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_pc      (instr_pc),
      .pc            (pc),
`ifdef FETCH_TIMEOUT_EN
      .fetch_err     (fetch_err),
`endif
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; fetch_en = 1'b0; branch_taken = 1'b0;
      branch_target = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      #1;
      chk("rst_pc", pc, 32'h100);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_instr", instr, 32'd0);

      // zero-wait fetch
      fetch_en = 1'b1; step();
      chk("f1_req", {31'd0, imem_req}, 32'd1);
      chk("f1_addr", imem_addr, 32'h100);
      chk("f1_busy", {31'd0, busy}, 32'd1);
      fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004; step();
      imem_ack = 1'b0;
      chk("f1_instr", instr, 32'h8C22_0004);
      chk("f1_ipc", instr_pc, 32'h100);
      chk("f1_pc", pc, 32'h104);
      chk("f1_valid", {31'd0, instr_valid}, 32'd1);
      chk("f1_busy0", {31'd0, busy}, 32'd0);

      // wait states with a branch latched mid-REQ
      fetch_en = 1'b1; step(); fetch_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ws_req", {31'd0, imem_req}, 32'd1);
         chk("ws_addr", imem_addr, 32'h104);
         chk("ws_busy", {31'd0, busy}, 32'd1);
         chk("ws_valid", {31'd0, instr_valid}, 32'd0);
         branch_taken = (i == 1); branch_target = 32'h200;
         imem_ack = (i == 2); imem_rdata = 32'h2008_0001;
         step();
         branch_taken = 1'b0; imem_ack = 1'b0;
      end
      chk("br_instr", instr, 32'h2008_0001);
      chk("br_ipc", instr_pc, 32'h104);
      chk("br_pc", pc, 32'h200);
      chk("br_valid", {31'd0, instr_valid}, 32'd1);

      // branch and fetch together in HOLD: branch wins, fetch follows from target
      branch_taken = 1'b1; branch_target = 32'h300; fetch_en = 1'b1; step();
      branch_taken = 1'b0; fetch_en = 1'b0;
      chk("bf_pc", pc, 32'h300);
      chk("bf_noreq", {31'd0, imem_req}, 32'd0);
      step();
      chk("bf_req", {31'd0, imem_req}, 32'd1);
      chk("bf_addr", imem_addr, 32'h300);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0020; step(); imem_ack = 1'b0;
      chk("bf_pc2", pc, 32'h304);
      chk("bf_ipc", instr_pc, 32'h300);

      // wrap at top of address space
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; step(); branch_taken = 1'b0;
      chk("wr_pc0", pc, 32'hFFFF_FFFC);
      fetch_en = 1'b1; step(); fetch_en = 1'b0;
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678; step(); imem_ack = 1'b0;
      chk("wr_pc", pc, 32'h0);
      chk("wr_ipc", instr_pc, 32'hFFFF_FFFC);

      // misaligned target is word-aligned
      branch_taken = 1'b1; branch_target = 32'h203; fetch_en = 1'b1; step();
      branch_taken = 1'b0; fetch_en = 1'b0;
      chk("al_pc", pc, 32'h200);
      step();
      chk("al_addr", imem_addr, 32'h200);
      imem_ack = 1'b1; step(); imem_ack = 1'b0;
      chk("al_pc2", pc, 32'h204);

      // branch on the ack cycle replaces PC+4
      fetch_en = 1'b1; step(); fetch_en = 1'b0;
      imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h400; imem_rdata = 32'hAAAA_5555;
      step();
      imem_ack = 1'b0; branch_taken = 1'b0;
      chk("ba_pc", pc, 32'h400);
      chk("ba_ipc", instr_pc, 32'h204);
      chk("ba_instr", instr, 32'hAAAA_5555);

      // ack outside REQ is ignored
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 1'b0;
      chk("ig_instr", instr, 32'hAAAA_5555);
      chk("ig_pc", pc, 32'h400);

      // asynchronous reset mid-REQ
      fetch_en = 1'b1; step(); fetch_en = 1'b0;
      chk("ar_req1", {31'd0, imem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_req0", {31'd0, imem_req}, 32'd0);
      chk("ar_pc", pc, 32'h100);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_valid", {31'd0, instr_valid}, 32'd0);
      chk("ar_instr", instr, 32'd0);
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000; step(); imem_ack = 1'b0;
      chk("ar_late_valid", {31'd0, instr_valid}, 32'd0);
      chk("ar_late_instr", instr, 32'd0);
      chk("ar_late_pc", pc, 32'h100);

`ifdef FETCH_TIMEOUT_EN
      // no ack: abort after 16 REQ cycles
      fetch_en = 1'b1; step(); fetch_en = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("to_busy", {31'd0, busy}, 32'd1);
      chk("to_err0", {31'd0, fetch_err}, 32'd0);
      step();
      chk("to_err1", {31'd0, fetch_err}, 32'd1);
      chk("to_instr", instr, 32'd0);
      chk("to_valid", {31'd0, instr_valid}, 32'd1);
      chk("to_pc", pc, 32'h100);
      chk("to_busy0", {31'd0, busy}, 32'd0);
      fetch_en = 1'b1; step(); fetch_en = 1'b0;
      chk("to_clr", {31'd0, fetch_err}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_000C; step(); imem_ack = 1'b0;
      chk("to_rec_pc", pc, 32'h104);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
